// File: rtl/g729_pkg.sv
// Shared types and saturation limits for the G.729-style MAC datapath.
// Limits are functions of the operand width so every user stays consistent.
package g729_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } mac_state_t;

    // Largest signed value representable in w bits (w <= 63)
    function automatic longint max_s(int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in w bits (w <= 63)
    function automatic longint min_s(int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/l_mult_sat.sv
// Saturating fractional multiply: p = 2*a*b, clamped for MIN*MIN.
// Purely combinational; the caller registers the result.
module l_mult_sat #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_p,
    output logic               o_ovf
);
    import g729_pkg::*;

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(min_s(WIDTH));
    localparam logic [W2-1:0]    MAX_2W = W2'(max_s(W2));

    logic [W2-1:0] w_ae;
    logic [W2-1:0] w_be;
    logic [W2-1:0] w_prod;

    assign w_ae   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_be   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_prod = w_ae * w_be;

    // Only MIN*MIN cannot be doubled within 2*WIDTH bits
    always_comb begin
        o_ovf = (i_a == MIN_W) && (i_b == MIN_W);
        o_p   = o_ovf ? MAX_2W : {w_prod[W2-2:0], 1'b0};
    end

endmodule

// File: rtl/l_mac_seq.sv
// Sequential L_mac / L_msu accumulator over a stream of operand pairs.
// Optional macro L_MAC_SEQ_ROUND_EN adds a rounded upper-half output.
module l_mac_seq #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               msu,
    input  logic [LEN_W-1:0]   len,
    input  logic [2*WIDTH-1:0] acc_init,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
`ifdef L_MAC_SEQ_ROUND_EN
    output logic [WIDTH-1:0]   round_out,
`endif
    output logic               overflow
);
    import g729_pkg::*;

    localparam int W2 = 2 * WIDTH;
    localparam logic [W2-1:0] MAX_2W = W2'(max_s(W2));
    localparam logic [W2-1:0] MIN_2W = W2'(min_s(W2));

    mac_state_t r_state;
    mac_state_t w_next;

    logic [W2-1:0]    r_acc;
    logic [W2-1:0]    r_p;
    logic [W2-1:0]    r_result;
    logic             r_p_vld;
    logic             r_msu;
    logic             r_ovf;
    logic             r_drn;
    logic [LEN_W-1:0] r_cnt;

    logic          w_start;
    logic          w_accept;
    logic [W2-1:0] w_p;
    logic          w_povf;
    logic [W2:0]   w_sum;
    logic          w_sat;
    logic [W2-1:0] w_acc_n;

    assign in_ready = (r_state == S_RUN);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign overflow = r_ovf;
    assign w_start  = (r_state == S_IDLE) && start;
    assign w_accept = in_valid && in_ready;

    l_mult_sat #(.WIDTH(WIDTH)) u_mult (
        .i_a   (a),
        .i_b   (b),
        .o_p   (w_p),
        .o_ovf (w_povf)
    );

    // Stage-2 add/subtract at one extra bit, then clamp
    always_comb begin
        w_sum = r_msu ? ({r_acc[W2-1], r_acc} - {r_p[W2-1], r_p})
                      : ({r_acc[W2-1], r_acc} + {r_p[W2-1], r_p});
        w_sat = w_sum[W2] != w_sum[W2-1];
        if (w_sat) begin
            w_acc_n = w_sum[W2] ? MIN_2W : MAX_2W;
        end else begin
            w_acc_n = w_sum[W2-1:0];
        end
    end

`ifdef L_MAC_SEQ_ROUND_EN
    logic [WIDTH-1:0] r_round;
    logic [W2:0]      w_rsum;
    logic             w_rsat;

    assign round_out = r_round;

    // Rounding can only push past the positive limit
    always_comb begin
        w_rsum = {r_acc[W2-1], r_acc} + {{(WIDTH + 1){1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};
        w_rsat = w_rsum[W2] != w_rsum[W2-1];
    end

    // Capture the rounded result alongside the full result
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_round <= '0;
        end else if (r_state == S_DRAIN && r_drn) begin
            r_round <= w_rsat ? MAX_2W[W2-1:WIDTH] : w_rsum[W2-1:WIDTH];
        end
    end
`else
    logic w_rsat;
    assign w_rsat = 1'b0;
`endif

    // Next-state logic for the run sequence
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && r_cnt == LEN_W'(1)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drn) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Run parameters, pair counter and the two-cycle drain timer
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_msu <= 1'b0;
            r_cnt <= '0;
            r_drn <= 1'b0;
        end else begin
            r_drn <= (r_state == S_DRAIN);
            if (w_start) begin
                r_msu <= msu;
                r_cnt <= len;
            end else if (w_accept) begin
                r_cnt <= r_cnt - LEN_W'(1);
            end
        end
    end

    // Product register, accumulator and sticky overflow
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_p     <= '0;
            r_p_vld <= 1'b0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_p_vld <= w_accept;
            if (w_accept) begin
                r_p <= w_p;
            end
            if (w_start) begin
                r_acc <= acc_init;
                r_ovf <= 1'b0;
            end else begin
                if (r_p_vld) begin
                    r_acc <= w_acc_n;
                end
                if ((w_accept && w_povf) || (r_p_vld && w_sat) ||
                    (r_state == S_DRAIN && r_drn && w_rsat)) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Publish the accumulator once the pipeline has drained
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_result <= '0;
        end else if (r_state == S_DRAIN && r_drn) begin
            r_result <= r_acc;
        end
    end

endmodule
